// File: rtl/layer2_temp_reader.sv
// ---------------------------------------------------------------------------
// layer2_temp_reader
//
// Consumer-side controller for the 64-entry layer-2 temp buffer. The layer-2
// controller fills the buffer in two halves; this block streams the stored
// activations, together with the matching weights, into the next layer's MAC
// once per output neuron. It starts on the first half, stalls at the half
// boundary until the second half lands, and releases the buffer at frame end.
//
// Optional feature macro: TEMP_RD_ERR_CHK_EN
//   When defined, adds the sticky overrun_o flag (cleared only by rst_i)
//   that records ready pulses arriving while their half is still occupied.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   half0_ready_i   1-cycle pulse: entries 0..HALF-1 written
//   half1_ready_i   1-cycle pulse: entries HALF..DEPTH-1 written
//   temp_rd_addr_o  temp buffer read address (k)
//   temp_rd_en_o    temp buffer read enable
//   w_addr_o        weight address, n*DEPTH + k
//   w_en_o          weight read enable (same as temp_rd_en_o)
//   mac_en_o        MAC accumulate enable (read enable delayed RD_LAT)
//   mac_clear_o     MAC restart, high with the first mac_en_o of a neuron
//   acc_valid_o     1-cycle pulse: accumulator holds final sum of neuron_idx_o
//   neuron_idx_o    neuron whose result is flagged by acc_valid_o
//   buf_free_o      1-cycle pulse: temp buffer may be overwritten
//   busy_o          high from the first read issue until done_o
//   done_o          1-cycle pulse: frame complete
//   overrun_o       (TEMP_RD_ERR_CHK_EN only) sticky ready-pulse overrun flag
// ---------------------------------------------------------------------------
module layer2_temp_reader #(
  parameter int DEPTH   = 64,
  parameter int HALF    = 32,
  parameter int NUM_OUT = 10,
  parameter int W_AW    = 10,
  parameter int RD_LAT  = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            half0_ready_i,
  input  logic            half1_ready_i,
  output logic [AW-1:0]   temp_rd_addr_o,
  output logic            temp_rd_en_o,
  output logic [W_AW-1:0] w_addr_o,
  output logic            w_en_o,
  output logic            mac_en_o,
  output logic            mac_clear_o,
  output logic            acc_valid_o,
  output logic [NW-1:0]   neuron_idx_o,
  output logic            buf_free_o,
  output logic            busy_o,
  output logic            done_o
`ifdef TEMP_RD_ERR_CHK_EN
  ,
  output logic            overrun_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STALL,
    DRAIN,
    FINISH
  } state_t;

  state_t state_q, state_d;

  // Issue pointer: k walks the buffer, n walks the output neurons.
  logic [AW-1:0]   k_q, k_d;
  logic [NW-1:0]   n_q, n_d;
  logic [W_AW-1:0] w_addr_q, w_addr_d;
  logic [1:0]      drain_cnt_q, drain_cnt_d;

  // Sticky "half has landed" flags.
  logic h0_q, h0_d;
  logic h1_q, h1_d;

  // Read-side tags delayed to line up with the memory read data.
  logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [RD_LAT-1:0] first_pipe_q, first_pipe_d;
  logic [RD_LAT-1:0] last_pipe_q, last_pipe_d;
  logic [NW-1:0]     n_pipe_q [RD_LAT];
  logic [NW-1:0]     n_pipe_d [RD_LAT];

  logic            acc_valid_q, acc_valid_d;
  logic [NW-1:0]   neuron_idx_q, neuron_idx_d;

  logic rd_en;
  logic finish;
  logic need_h1;
  logic last_read;

  // Main sequencer: walks (n, k) one read per cycle, holding at the half
  // boundary of neuron 0 until the second half is present, then drains the
  // read pipeline before signalling frame completion.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    w_addr_d    = w_addr_q;
    drain_cnt_d = drain_cnt_q;
    rd_en       = 1'b0;
    finish      = 1'b0;

    // Only the very first neuron can outrun the writer; later neurons always
    // find both halves present.
    need_h1   = (n_q == '0) && (k_q >= AW'(HALF)) && !h1_q;
    last_read = (n_q == NW'(NUM_OUT - 1)) && (k_q == AW'(DEPTH - 1));

    unique case (state_q)
      IDLE: begin
        if (h0_q || half0_ready_i) begin
          state_d  = RUN;
          k_d      = '0;
          n_d      = '0;
          w_addr_d = '0;
        end
      end

      RUN: begin
        if (need_h1) begin
          // A half1 pulse in this very cycle sets h1 for the next cycle, so
          // staying in RUN issues the read right after the pulse.
          if (!half1_ready_i) begin
            state_d = STALL;
          end
        end else begin
          rd_en    = 1'b1;
          w_addr_d = w_addr_q + W_AW'(1);
          if (last_read) begin
            k_d         = '0;
            n_d         = '0;
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end else if (k_q == AW'(DEPTH - 1)) begin
            k_d = '0;
            n_d = n_q + NW'(1);
          end else begin
            k_d = k_q + AW'(1);
          end
        end
      end

      STALL: begin
        if (h1_q || half1_ready_i) begin
          state_d = RUN;
        end
      end

      DRAIN: begin
        if (drain_cnt_q == 2'(RD_LAT - 1)) begin
          state_d = FINISH;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end

      FINISH: begin
        finish   = 1'b1;
        state_d  = IDLE;
        k_d      = '0;
        n_d      = '0;
        w_addr_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Half flags: set by their ready pulse, cleared when the buffer is freed.
  // A pulse coinciding with the free keeps its flag set.
  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    if (finish) begin
      h0_d = 1'b0;
      h1_d = 1'b0;
    end
    if (half0_ready_i) begin
      h0_d = 1'b1;
    end
    if (half1_ready_i) begin
      h1_d = 1'b1;
    end
  end

  // Delay line carrying the read enable and the k/n tags alongside the data
  // coming back from the memories, plus the end-of-neuron result flag.
  always_comb begin
    en_pipe_d[0]    = rd_en;
    first_pipe_d[0] = rd_en && (k_q == '0);
    last_pipe_d[0]  = rd_en && (k_q == AW'(DEPTH - 1));
    n_pipe_d[0]     = n_q;
    for (int i = 1; i < RD_LAT; i++) begin
      en_pipe_d[i]    = en_pipe_q[i-1];
      first_pipe_d[i] = first_pipe_q[i-1];
      last_pipe_d[i]  = last_pipe_q[i-1];
      n_pipe_d[i]     = n_pipe_q[i-1];
    end

    // The accumulator is final one cycle after the last product of a neuron
    // has been added.
    acc_valid_d  = en_pipe_q[RD_LAT-1] && last_pipe_q[RD_LAT-1];
    neuron_idx_d = neuron_idx_q;
    if (acc_valid_d) begin
      neuron_idx_d = n_pipe_q[RD_LAT-1];
    end
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      k_q          <= '0;
      n_q          <= '0;
      w_addr_q     <= '0;
      drain_cnt_q  <= '0;
      h0_q         <= 1'b0;
      h1_q         <= 1'b0;
      en_pipe_q    <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      n_pipe_q     <= '{default: '0};
      acc_valid_q  <= 1'b0;
      neuron_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      n_q          <= n_d;
      w_addr_q     <= w_addr_d;
      drain_cnt_q  <= drain_cnt_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      en_pipe_q    <= en_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
      n_pipe_q     <= n_pipe_d;
      acc_valid_q  <= acc_valid_d;
      neuron_idx_q <= neuron_idx_d;
    end
  end

  assign temp_rd_addr_o = k_q;
  assign temp_rd_en_o   = rd_en;
  assign w_addr_o       = w_addr_q;
  assign w_en_o         = rd_en;
  assign mac_en_o       = en_pipe_q[RD_LAT-1];
  assign mac_clear_o    = en_pipe_q[RD_LAT-1] && first_pipe_q[RD_LAT-1];
  assign acc_valid_o    = acc_valid_q;
  assign neuron_idx_o   = neuron_idx_q;
  assign buf_free_o     = finish;
  assign done_o         = finish;
  assign busy_o         = (state_q != IDLE);

`ifdef TEMP_RD_ERR_CHK_EN
  logic overrun_q, overrun_d;

  // Overrun: a ready pulse for a half that is still occupied, including a
  // fresh half0 while the current frame is still reading it.
  always_comb begin
    overrun_d = overrun_q;
    if ((half0_ready_i && h0_q) || (half1_ready_i && h1_q) ||
        (half0_ready_i && busy_o && h0_q)) begin
      overrun_d = 1'b1;
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun_o = overrun_q;
`endif

endmodule
